// File: rtl/mod_seq.sv
// ---------------------------------------------------------------------------
// mod_seq -- sequential 64-bit by 16-bit unsigned modulo unit.
//
// Computes in_a mod in_m with a restoring shift-subtract loop, one dividend
// bit per clock, most significant bit first. The loop runs for 64 cycles
// from the accept edge. The result is held in DONE until the consumer takes
// it.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    requester offers an operand pair
//   in_ready    operands accepted (high only in IDLE)
//   in_a        64-bit unsigned dividend
//   in_m        16-bit unsigned modulus
//   out_valid   result available (high only in DONE)
//   out_ready   consumer accepts the result
//   out_result  in_a mod in_m, stable while out_valid=1
//   out_err     (MOD_DIV0_ERR_EN only) operand pair had in_m=0
//   busy        high while the loop is running
//
// Configuration
//   MOD_DIV0_ERR_EN  when defined, in_m=0 skips the loop and goes straight
//                    to DONE with out_result=0 and out_err=1. When it is not
//                    defined, in_m=0 runs the normal loop and yields
//                    in_a[15:0].
// ---------------------------------------------------------------------------
module mod_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_a,
   input  logic [15:0] in_m,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
`ifdef MOD_DIV0_ERR_EN
   output logic        out_err,
`endif
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [63:0] a_reg;
   logic [15:0] m_reg;
   logic [15:0] r;
   logic [5:0]  idx;

   // One restoring step. Because r < m_reg holds on entry, t < 2*m_reg, so
   // t - m_reg always fits in 16 bits. The compare uses the full 17-bit t.
   // With m_reg = 0 the subtraction is a plain shift, which leaves a[15:0]
   // in r.
   logic [16:0] t;
   logic [16:0] diff;
   logic [15:0] r_next;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here unconditionally first), otherwise synthesis infers a latch.
   always_comb begin
      t      = {r, a_reg[idx]};
      diff   = t - {1'b0, m_reg};
      r_next = t[15:0];
      if (t >= {1'b0, m_reg}) begin
         r_next = diff[15:0];
      end
   end

   // Operand registers. They need no reset: they are reloaded on every
   // accept and are only read in BUSY.
   // NOTE: a datapath register that is always written before it is read is
   // left out of reset. This keeps the reset tree small and avoids a
   // useless reset mux.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_reg <= in_a;
         m_reg <= in_m;
      end
   end

   // Control FSM. All outputs are registered here.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge, whatever the order of
   // the statements.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         r          <= '0;
         idx        <= 6'd63;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         out_result <= '0;
`ifdef MOD_DIV0_ERR_EN
         out_err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r        <= '0;
                  idx      <= 6'd63;
                  in_ready <= 1'b0;
`ifdef MOD_DIV0_ERR_EN
                  if (in_m == '0) begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     out_result <= '0;
                     out_err    <= 1'b1;
                  end else
`endif
                  begin
                     state   <= BUSY;
                     busy    <= 1'b1;
`ifdef MOD_DIV0_ERR_EN
                     out_err <= 1'b0;
`endif
                  end
               end
            end

            BUSY: begin
               r   <= r_next;
               idx <= idx - 6'd1;
               if (idx == 6'd0) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  out_valid  <= 1'b1;
                  out_result <= r_next;
               end
            end

            DONE: begin
               // in_ready stays low through the handshake edge. The next
               // accept can therefore happen one cycle later at the earliest.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_seq.sv
// ---------------------------------------------------------------------------
// tb_mod_seq -- self-checking bench for mod_seq.
//
// Results are compared with a % m, which is computed with 64-bit arithmetic
// inside the bench. The bench runs directed cases first and then randomized
// operand pairs. It also covers MOD_DIV0_ERR_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_mod_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [15:0] in_m;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        busy;
`ifdef MOD_DIV0_ERR_EN
   logic        out_err;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mod_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_m       (in_m),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
`ifdef MOD_DIV0_ERR_EN
      .out_err    (out_err),
`endif
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: the arithmetic remainder, plus the rules for m = 0.
   function automatic logic [15:0] ref_mod(input logic [63:0] a, input logic [15:0] m);
      logic [63:0] rem;
      if (m == 16'd0) begin
`ifdef MOD_DIV0_ERR_EN
         return 16'd0;
`else
         return a[15:0];
`endif
      end
      rem = a % {48'd0, m};
      return rem[15:0];
   endfunction

   // Number of edges after the accept edge until out_valid is seen.
   function automatic int ref_latency(input logic [15:0] m);
`ifdef MOD_DIV0_ERR_EN
      if (m == 16'd0) return 0;
`endif
      return 64;
   endfunction

   // Presents one operand pair. It waits for the result and checks it,
   // applies 'hold' cycles of backpressure, and then completes the handshake.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [15:0] m,
                         input int hold);
      int          cycles;
      bit          ready_low;
      bit          busy_high;
      bit          stable;
      logic [15:0] exp;
      int          exp_lat;
      exp     = ref_mod(a, m);
      exp_lat = ref_latency(m);
      check({tag, "_in_ready_idle"}, in_ready, 1);
      in_valid  = 1'b1;
      in_a      = a;
      in_m      = m;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      // Scramble the operand inputs after the accept edge. The result must
      // not depend on them.
      in_valid  = 1'b0;
      in_a      = {$urandom, $urandom};
      in_m      = 16'($urandom);
      cycles    = 0;
      ready_low = 1'b1;
      busy_high = 1'b1;
      while (!out_valid && cycles < 200) begin
         ready_low &= !in_ready;
         busy_high &= busy;
         @(posedge clk); #1;
         cycles++;
      end
      if (!out_valid) begin
         check({tag, "_timeout"}, 0, 1);
         return;
      end
      check({tag, "_latency"}, cycles, exp_lat);
      check({tag, "_result"}, out_result, exp);
      check({tag, "_in_ready_busy"}, ready_low, 1);
      if (exp_lat > 0) check({tag, "_busy_high"}, busy_high, 1);
      check({tag, "_in_ready_done"}, in_ready, 0);
      check({tag, "_busy_done"}, busy, 0);
`ifdef MOD_DIV0_ERR_EN
      check({tag, "_err"}, out_err, (m == 16'd0));
`endif
      stable = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         stable &= out_valid && (out_result == exp) && !in_ready;
      end
      if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_ready_back"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      bit saw_valid;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_m      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_result", out_result, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef MOD_DIV0_ERR_EN
      check("rst_out_err", out_err, 0);
`endif

      // Basic case, with out_ready held high.
      run_op("basic", 64'd94, 16'd89, 0);
      // Back-to-back operations.
      run_op("b2b_0", 64'd11840462074477813509, 16'd59676, 0);
      run_op("b2b_1", 64'd9630541272125196104, 16'd6018, 0);
      // Backpressure.
      run_op("bp", 64'd15156998188708966964, 16'd50314, 10);

      // Reset in the middle of an operation.
      in_valid = 1'b1;
      in_a     = 64'd75;
      in_m     = 16'd46;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_result", out_result, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         saw_valid |= out_valid;
      end
      check("midrst_no_valid", saw_valid, 0);
      run_op("after_rst", 64'd66, 16'd36, 0);

      // Zero modulus, then boundary cases.
      run_op("m_zero", 64'h1234, 16'd0, 2);
      run_op("max_a", 64'hFFFF_FFFF_FFFF_FFFF, 16'd65535, 0);
      run_op("a_lt_m", 64'd33, 16'd48, 1);
      run_op("m_one", 64'd76, 16'd1, 0);

      // Randomized operand pairs.
      for (int i = 0; i < 20; i++) begin
         logic [63:0] a;
         logic [15:0] m;
         a = {$urandom, $urandom} >> $urandom_range(0, 63);
         m = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 20))
                                         : 16'($urandom_range(1, 65535));
         run_op($sformatf("rand%0d", i), a, m, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_seq.md
MOD_SEQ -- requirements
Module: mod_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  requester offers an operand pair.
REQ-004 SHALL have port: in_ready  output  1  block can accept operands; high only in IDLE.
REQ-005 SHALL have port: in_a  input  64  unsigned dividend.
REQ-006 SHALL have port: in_m  input  16  unsigned modulus.
REQ-007 SHALL have port: out_valid  output  1  result available; high only in DONE.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port: out_result  output  16  in_a mod in_m; held stable while out_valid=1.
REQ-010 SHALL have port, only when MOD_DIV0_ERR_EN is defined: out_err  output  1  operand pair had in_m=0.
REQ-011 SHALL have port: busy  output  1  high in BUSY.

Function
REQ-012 SHALL implement FSM with states IDLE, BUSY and DONE.
REQ-013 SHALL accept operands on the rising edge where in_valid=1 and in_ready=1, latching in_a and in_m into internal registers and moving to BUSY with bit index 63.
REQ-014 SHALL ignore in_a and in_m changes after acceptance.
REQ-015 SHALL in each BUSY cycle form the 17-bit value t={r[15:0], a_reg[idx]}; if t>=m_reg then r=t-m_reg, else r=t; then decrement idx.
REQ-016 SHALL process exactly 64 BUSY cycles (idx 63 down to 0), so that out_valid rises on the 64th edge after the accept edge.
REQ-017 SHALL hold the remainder in a 16-bit register; t-m_reg SHALL always fit in 16 bits, and no bit SHALL be truncated from t before the compare.
REQ-018 SHALL keep out_result=r and out_valid=1 in DONE until out_ready=1; on that edge it SHALL return to IDLE.
REQ-019 SHALL keep in_ready=0 in DONE, including in the out_ready cycle; the next accept happens no earlier than one cycle after the return to IDLE.
REQ-020 SHALL hold out_result at its last value in IDLE and BUSY; out_result is only meaningful while out_valid=1.
REQ-021 SHALL give m=1 a result of 0, and any a<m a result equal to a[15:0].

Reset
REQ-022 SHALL on rst_n=0, immediately and regardless of clk, force state=IDLE, r=0, idx=63, out_valid=0, busy=0, out_result=0 and out_err=0.
REQ-023 SHALL drive in_ready=1 once reset is released.
REQ-024 SHALL discard any operation in progress when reset is asserted mid-operation, and no out_valid pulse for it SHALL follow.

Configuration
REQ-025 SHALL, with MOD_DIV0_ERR_EN defined, on acceptance with in_m=0 go straight to DONE on the next edge with out_result=0 and out_err=1, skipping BUSY; out_err SHALL be 0 for all other results.
REQ-026 SHALL, without MOD_DIV0_ERR_EN, omit out_err and treat in_m=0 like any other modulus: 64 BUSY cycles, result in_a[15:0].

Verification
REQ-027 SHALL check: a=94, m=89, out_ready=1 -> out_valid on the 64th edge after accept, out_result=5, return to IDLE on the next edge.
REQ-028 SHALL check back-to-back operands a=11840462074477813509/m=59676, then a=9630541272125196104/m=6018 -> results 19113 and 1922, with in_ready=0 throughout each operation.
REQ-029 SHALL check backpressure: a=15156998188708966964, m=50314, out_ready held 0 for 10 cycles -> out_result=836 stable, out_valid stays 1, in_ready stays 0.
REQ-030 SHALL check reset mid-operation: a=75, m=46, rst_n pulsed low at BUSY cycle 30 -> outputs 0 at once, no out_valid; a new request a=66, m=36 -> 30.
REQ-031 SHALL check m=0 with a=0x1234: with MOD_DIV0_ERR_EN -> DONE after 1 cycle, result 0, out_err=1; without it -> result 0x1234 after 64 cycles.
REQ-032 SHALL check boundaries: a=2^64-1, m=65535 -> 0; a=33, m=48 -> 33; a=76, m=1 -> 0.
